// File: rtl/sprite_fetcher.sv
// sprite_fetcher: fetches sprite row bitplanes from VRAM and merges pixels into an 8-slot priority FIFO
module sprite_fetcher (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        isGBC,
  input  logic        sprite_fetch,
  input  logic [10:0] sprite_addr,
  input  logic [7:0]  sprite_attr,
  input  logic [3:0]  sprite_index,
  output logic        sprite_fetch_done,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  input  logic        line_start,
  input  logic        pix_shift,
  output logic [1:0]  spr_color,
  output logic        spr_bg_prio,
  output logic        spr_dmg_pal,
  output logic [2:0]  spr_cgb_pal
);
  typedef enum logic [2:0] {IDLE, W1, W2, LO, HI, DONE} state_t;
  state_t     state;
  logic [7:0] lo;
  logic       flip;
  logic [4:0] attr_q;
  logic [3:0] idx_q;
  logic [1:0] col [8];
  logic [4:0] pat [8];
  logic [3:0] pid [8];
  logic [1:0] n_col [8];
  logic [4:0] n_pat [8];
  logic [3:0] n_pid [8];
  logic       fetching;
  logic       unused_attr;
  assign unused_attr       = sprite_attr[6];
  assign fetching          = state == LO || state == HI;
  assign vram_rd           = fetching;
  assign vram_addr         = fetching ? {1'b0, sprite_addr, state == HI} : 13'd0;
  assign vram_bank         = fetching & isGBC & sprite_attr[3];
  assign sprite_fetch_done = state == DONE;
  assign spr_color         = col[0];
  assign spr_bg_prio       = pat[0][4];
  assign spr_dmg_pal       = pat[0][3];
  assign spr_cgb_pal       = pat[0][2:0];
  for (genvar i = 0; i < 8; i++) begin : g_slot
    logic [1:0] s_col;
    logic [1:0] pc;
    logic [4:0] s_pat;
    logic [3:0] s_pid;
    logic       wr;
    if (i < 7) begin : g_next
      assign s_col = pix_shift ? col[i+1] : col[i];
      assign s_pat = pix_shift ? pat[i+1] : pat[i];
      assign s_pid = pix_shift ? pid[i+1] : pid[i];
    end else begin : g_tail
      assign s_col = pix_shift ? 2'd0 : col[i];
      assign s_pat = pix_shift ? 5'd0 : pat[i];
      assign s_pid = pix_shift ? 4'hF : pid[i];
    end
    assign pc       = flip ? {vram_data[i], lo[i]} : {vram_data[7-i], lo[7-i]};
    assign wr       = state == HI && pc != 2'd0 && (s_col == 2'd0 || (isGBC && idx_q < s_pid));
    assign n_col[i] = wr ? pc : s_col;
    assign n_pat[i] = wr ? attr_q : s_pat;
    assign n_pid[i] = wr ? idx_q : s_pid;
  end
  // fetch sequencer, plane latches and FIFO update (shift first, merge on HI exit)
  always_ff @(posedge clk) begin
    if (reset || (ce && line_start)) begin
      state  <= IDLE;
      lo     <= 8'd0;
      flip   <= 1'b0;
      attr_q <= 5'd0;
      idx_q  <= 4'hF;
      for (int k = 0; k < 8; k++) begin
        col[k] <= 2'd0;
        pat[k] <= 5'd0;
        pid[k] <= 4'hF;
      end
    end else if (ce) begin
      state <= state == IDLE ? (sprite_fetch ? W1 : IDLE) : state == DONE ? IDLE : state_t'(state + 3'd1);
      if (state == LO) begin
        lo     <= vram_data;
        flip   <= sprite_attr[5];
        attr_q <= {sprite_attr[7], sprite_attr[4], sprite_attr[2:0]};
        idx_q  <= sprite_index;
      end
      for (int k = 0; k < 8; k++) begin
        col[k] <= n_col[k];
        pat[k] <= n_pat[k];
        pid[k] <= n_pid[k];
      end
    end
  end
endmodule

// File: tb/tb_sprite_fetcher.sv
// tb_sprite_fetcher: randomized scoreboard bench for sprite_fetcher against a slot-level FIFO model
module tb_sprite_fetcher;
  logic        clk = 0, reset = 1, ce = 0, isGBC = 0, sprite_fetch = 0, line_start = 0, pix_shift = 0;
  logic [10:0] sprite_addr = 0;
  logic [7:0]  sprite_attr = 0;
  logic [3:0]  sprite_index = 0;
  logic        sprite_fetch_done, vram_bank, vram_rd;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic [1:0]  spr_color;
  logic        spr_bg_prio, spr_dmg_pal;
  logic [2:0]  spr_cgb_pal;
  logic [7:0]  mem [2][8192];
  int          compared = 0, mismatched = 0, ce_cnt = 0;
  int          done_at[$];
  logic [6:0]  exp_q[$];
  logic [1:0]  m_col [8];
  logic [4:0]  m_at [8];
  logic [3:0]  m_id [8];
  logic        prev_done = 0;

  sprite_fetcher dut (
    .clk(clk), .reset(reset), .ce(ce), .isGBC(isGBC),
    .sprite_fetch(sprite_fetch), .sprite_addr(sprite_addr), .sprite_attr(sprite_attr),
    .sprite_index(sprite_index), .sprite_fetch_done(sprite_fetch_done),
    .vram_addr(vram_addr), .vram_bank(vram_bank), .vram_rd(vram_rd), .vram_data(vram_data),
    .line_start(line_start), .pix_shift(pix_shift), .spr_color(spr_color),
    .spr_bg_prio(spr_bg_prio), .spr_dmg_pal(spr_dmg_pal), .spr_cgb_pal(spr_cgb_pal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) vram_data <= mem[vram_bank][vram_addr];

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 8; k++) begin
      m_col[k] = 0;
      m_at[k] = 0;
      m_id[k] = 4'hF;
    end
  endtask

  task automatic m_shift();
    exp_q.push_back({m_col[0], m_at[0]});
    for (int k = 0; k < 7; k++) begin
      m_col[k] = m_col[k+1];
      m_at[k] = m_at[k+1];
      m_id[k] = m_id[k+1];
    end
    m_col[7] = 0;
    m_at[7] = 0;
    m_id[7] = 4'hF;
  endtask

  task automatic m_merge(input logic [10:0] a, input logic [7:0] at, input logic [3:0] id);
    logic       b;
    logic [7:0] lo, hi;
    logic [1:0] c;
    b = isGBC & at[3];
    lo = mem[b][{1'b0, a, 1'b0}];
    hi = mem[b][{1'b0, a, 1'b1}];
    for (int i = 0; i < 8; i++) begin
      int s;
      s = at[5] ? i : 7 - i;
      c = {hi[s], lo[s]};
      if (c != 0 && (m_col[i] == 0 || (isGBC && id < m_id[i]))) begin
        m_col[i] = c;
        m_at[i] = {at[7], at[4], at[2:0]};
        m_id[i] = id;
      end
    end
  endtask

  // scoreboard monitor: one expected slot-0 pixel per consumed LCD pixel, plus done-pulse spacing
  always @(negedge clk) begin
    if (ce && !reset) begin
      ce_cnt++;
      if (sprite_fetch_done) begin
        chk("done_low_before_pulse", prev_done, 0);
        done_at.push_back(ce_cnt);
      end
      prev_done = sprite_fetch_done;
      if (pix_shift && !line_start) begin
        if (exp_q.size() == 0) chk("pixel_unexpected", 1, 0);
        else chk("pixel", {spr_color, spr_bg_prio, spr_dmg_pal, spr_cgb_pal}, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic sh, input logic ls);
    repeat ($urandom_range(1, 2)) begin
      ce = 0;
      pix_shift = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    ce = 1;
    pix_shift = sh;
    line_start = ls;
    if (ls) m_clear();
    else if (sh) m_shift();
    @(negedge clk);
  endtask

  task automatic end_step();
    @(posedge clk);
    #1;
    ce = 0;
    pix_shift = 0;
    line_start = 0;
  endtask

  task automatic fetch(input logic [10:0] a, input logic [7:0] at, input logic [3:0] id,
                       input logic [5:0] shm, input int abort_k, input int abort_kind);
    sprite_fetch = 1;
    sprite_addr = a;
    sprite_attr = at;
    sprite_index = id;
    for (int k = 1; k <= 6; k++) begin
      if (k == abort_k) begin
        if (abort_kind == 1) begin
          step(0, 1);
          end_step();
        end else begin
          ce = 0;
          reset = 1;
          m_clear();
          @(posedge clk);
          #1;
          reset = 0;
        end
        sprite_fetch = 0;
        chk("abort_vram_rd", vram_rd, 0);
        chk("abort_color", spr_color, 0);
        chk("abort_done", sprite_fetch_done, 0);
        break;
      end
      step(shm[k-1], 0);
      chk("vram_rd", vram_rd, int'(k == 4 || k == 5));
      if (k == 4 || k == 5) begin
        chk("vram_addr", vram_addr, {1'b0, a, k == 5});
        chk("vram_bank", vram_bank, isGBC & at[3]);
      end
      chk("fetch_done", sprite_fetch_done, int'(k == 6));
      if (k == 5) m_merge(a, at, id);
      end_step();
    end
    sprite_fetch = 0;
    if (abort_k != 0) begin
      step(0, 0);
      chk("abort_no_done", sprite_fetch_done, 0);
      chk("abort_idle_rd", vram_rd, 0);
      end_step();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) begin
      step(1, 0);
      end_step();
    end
  endtask

  task automatic set_row(input logic b, input logic [10:0] a, input logic [7:0] lo, input logic [7:0] hi);
    mem[b][{1'b0, a, 1'b0}] = lo;
    mem[b][{1'b0, a, 1'b1}] = hi;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 8192; a++) mem[b][a] = 8'($urandom);
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("reset_color", spr_color, 0);
    chk("reset_prio_pals", {spr_bg_prio, spr_dmg_pal, spr_cgb_pal}, 0);
    chk("reset_done", sprite_fetch_done, 0);
    chk("reset_vram", {vram_rd, vram_bank, vram_addr}, 0);
    // single sprite and X flip
    set_row(0, 11'h123, 8'hF0, 8'hCC);
    fetch(11'h123, 8'h00, 4'd0, 6'd0, 0, 0);
    chk("single_first_color", spr_color, 3);
    drain();
    fetch(11'h123, 8'h20, 4'd0, 6'd0, 0, 0);
    chk("flip_first_color", spr_color, 0);
    drain();
    // overlap priority, back-to-back requests
    set_row(0, 11'h010, 8'hFF, 8'h00);
    set_row(0, 11'h020, 8'h00, 8'hFF);
    set_row(1, 11'h010, 8'hFF, 8'h00);
    set_row(1, 11'h020, 8'h00, 8'hFF);
    fetch(11'h010, 8'h01, 4'd2, 6'd0, 0, 0);
    fetch(11'h020, 8'h02, 4'd1, 6'd0, 0, 0);
    chk("b2b_spacing", done_at[done_at.size()-1] - done_at[done_at.size()-2], 6);
    chk("dmg_overlap_color", spr_color, 1);
    drain();
    isGBC = 1;
    fetch(11'h010, 8'h09, 4'd2, 6'd0, 0, 0);
    fetch(11'h020, 8'h0A, 4'd1, 6'd0, 0, 0);
    chk("gbc_overlap_color", spr_color, 2);
    drain();
    isGBC = 0;
    // transparency
    set_row(0, 11'h030, 8'h0F, 8'h00);
    set_row(0, 11'h040, 8'hFF, 8'h00);
    fetch(11'h030, 8'h03, 4'd5, 6'd0, 0, 0);
    fetch(11'h040, 8'h14, 4'd6, 6'd0, 0, 0);
    drain();
    // aborts
    fetch(11'h123, 8'h00, 4'd0, 6'd0, 0, 0);
    fetch(11'h040, 8'h00, 4'd1, 6'd0, 5, 1);
    fetch(11'h123, 8'h00, 4'd0, 6'd0, 0, 0);
    fetch(11'h040, 8'h00, 4'd1, 6'd0, 4, 2);
    // line_start beats a coincident request
    sprite_fetch = 1;
    step(0, 1);
    end_step();
    sprite_fetch = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0);
      chk("coincide_no_fetch", vram_rd, 0);
      end_step();
    end
    // randomized mix of fetches, shifts and line starts
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: fetch(11'($urandom), 8'($urandom), 4'($urandom_range(0, 9)), 6'($urandom), 0, 0);
        3, 4: repeat ($urandom_range(1, 4)) begin
          step(1, 0);
          end_step();
        end
        default: begin
          isGBC = 1'($urandom_range(0, 1));
          step(1'($urandom_range(0, 1)), 1);
          end_step();
        end
      endcase
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
